uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmitter among up to NUM_REQ byte sources, e.g. the debounced push-button path and on-chip status generators. It grants one requester per byte, issues a one-cycle start strobe with the latched byte to the transmitter, and tracks the transmitter's busy flag through the frame. It enforces a programmable idle gap between frames before re-arbitrating.

---
 rtl/uart_tx_arbiter_if.sv | 18 +
 rtl/uart_tx_arbiter.sv | 112 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and transmitter signals of the UART transmit arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  localparam int IDW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic [IDW-1:0]            grant_id;
  logic                      active;
  logic                      err;
  modport master (output req, req_data, tx_busy, input ack, tx_start, tx_data, grant_id, active, err);
  modport slave  (input req, req_data, tx_busy, output ack, tx_start, tx_data, grant_id, active, err);
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter, one byte per grant, idle gap between frames
// UART_ARB_TIMEOUT_EN adds a WAIT_BUSY watchdog that pulses err and skips the stalled byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus
);
  localparam int IDW     = $clog2(NUM_REQ);
  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GAP} state_e;

  state_e              state_q, state_d, after_frame;
  logic [IDW-1:0]      ptr_q, ptr_d, grant_q, grant_d, sel;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                start_q, start_d, active_q, active_d;
  logic [CW-1:0]       cnt_q, cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
  logic                err_q, err_d;
`endif

  assign after_frame = (GAP_CYCLES == 0) ? IDLE : GAP;

  // Descending scan so the set bit nearest to ptr wins.
  always_comb begin
    sel = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req[(int'(ptr_q) + k) % NUM_REQ]) sel = IDW'((int'(ptr_q) + k) % NUM_REQ);
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    ack_d    = '0;
    start_d  = 1'b0;
    cnt_d    = cnt_q + CW'(1);
`ifdef UART_ARB_TIMEOUT_EN
    err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: if (|bus.req) begin
        state_d = START;
        grant_d = sel;
        data_d  = bus.req_data[int'(sel)*DATA_W +: DATA_W];
        start_d = 1'b1;
        ack_d   = NUM_REQ'(1) << sel;
      end
      START: begin
        state_d = WAIT_BUSY;
        ptr_d   = (grant_q == IDW'(NUM_REQ - 1)) ? '0 : grant_q + IDW'(1);
      end
      WAIT_BUSY: if (bus.tx_busy) state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = after_frame;
        err_d   = 1'b1;
      end
`endif
      WAIT_DONE: if (!bus.tx_busy) state_d = after_frame;
      GAP: if (cnt_q == GAP_LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cnt_d    = (state_d != state_q) ? '0 : cnt_d;
    active_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      data_q   <= '0;
      ack_q    <= '0;
      start_q  <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      start_q  <= start_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ack      = ack_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
  assign bus.grant_id = grant_q;
  assign bus.active   = active_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter (GAP_CYCLES=4 main instance, GAP_CYCLES=0 second instance)
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, GAP = 4, TMO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();
  uart_tx_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus0 ();

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  typedef struct { logic [1:0] id; logic [7:0] d; } exp_t;
  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   rem[N] = '{0, 0, 0, 0};
  bit   model_en = 1'b0;
  int   busy_len = 6;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rem[i];
    return s;
  endfunction

  task automatic wait_idle(input string name);
    int t = 0;
    cyc(2);
    while (t < 3000 && !(pending() == 0 && bus.active === 1'b0 && bus.tx_busy === 1'b0)) begin
      cyc(1);
      t++;
    end
    if (t >= 3000) fail(name);
  endtask

  task automatic wait_start(input string name);
    int t = 0;
    while (t < 500 && bus.tx_start !== 1'b1) begin
      cyc(1);
      t++;
    end
    if (t >= 500) fail(name);
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_ack"}, bus.ack, 0);
    chk({name, "_tx_start"}, bus.tx_start, 0);
    chk({name, "_tx_data"}, bus.tx_data, 0);
    chk({name, "_grant_id"}, bus.grant_id, 0);
    chk({name, "_active"}, bus.active, 0);
    chk({name, "_err"}, bus.err, 0);
  endtask

  // Monitor: every start strobe must match the next expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: grant_id %0d tx_data %0h", bus.grant_id, bus.tx_data);
        end else begin
          e = sb.pop_front();
          chk("grant_id", bus.grant_id, e.id);
          chk("tx_data", bus.tx_data, e.d);
          chk("ack", bus.ack, 32'(1) << e.id);
        end
      end
    end
  end

  // Requesters: rem[i] bytes outstanding, req held until the last ack.
  initial begin
    bus.req = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.ack[i] === 1'b1 && rem[i] > 0) rem[i]--;
        bus.req[i] = rem[i] != 0;
      end
    end
  end

  // Transmitter model: busy 3 cycles after the strobe, for busy_len cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && bus.tx_start === 1'b1) begin
        cyc(3);
        bus.tx_busy = 1'b1;
        cyc(busy_len);
        bus.tx_busy = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

  initial begin
    int t;
    bus.req_data  = '0;
    bus0.req      = '0;
    bus0.req_data = {8'h00, 8'h00, 8'h32, 8'h31};
    bus0.tx_busy  = 1'b0;
    cyc(3);
    chk_reset("rst");
    rst_n = 1'b1;
    cyc(2);

    // Single request with bench-driven busy to check gap timing
    bus.req_data = {8'h00, 8'h00, 8'h00, 8'hA5};
    sb.push_back('{2'd0, 8'hA5});
    rem[0] = 1;
    wait_start("single_start");
    cyc(3);
    bus.tx_busy = 1'b1;
    cyc(100);
    bus.tx_busy = 1'b0;
    cyc(GAP);
    chk("single_active_in_gap", bus.active, 1);
    cyc(1);
    chk("single_active_low", bus.active, 0);
    wait_idle("single_idle");
    model_en = 1'b1;

    // Round-robin after reset: ptr back to 0
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    bus.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    sb.push_back('{2'd0, 8'h10});
    sb.push_back('{2'd1, 8'h11});
    sb.push_back('{2'd2, 8'h12});
    sb.push_back('{2'd3, 8'h13});
    sb.push_back('{2'd0, 8'h10});
    rem = '{2, 1, 1, 1};
    wait_idle("rr_idle");

    // Rotation skip: grant 1 leaves ptr=2, then 0 before 1
    sb.push_back('{2'd1, 8'h11});
    rem[1] = 1;
    wait_idle("skip_a_idle");
    sb.push_back('{2'd0, 8'h10});
    sb.push_back('{2'd1, 8'h11});
    rem[0] = 1;
    rem[1] = 1;
    wait_idle("skip_b_idle");

    // Reset during WAIT_DONE
    bus.req_data = {8'h13, 8'h77, 8'h11, 8'h10};
    busy_len = 10;
    sb.push_back('{2'd2, 8'h77});
    rem[2] = 1;
    t = 0;
    while (t < 200 && bus.tx_busy !== 1'b1) begin cyc(1); t++; end
    if (t >= 200) fail("midrst_busy");
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    t = 0;
    while (t < 200 && bus.tx_busy !== 1'b0) begin cyc(1); t++; end
    if (t >= 200) fail("midrst_busy_low");
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    bus.req_data = {8'h13, 8'h42, 8'h11, 8'h10};
    sb.push_back('{2'd2, 8'h42});
    rem[2] = 1;
    wait_idle("midrst_idle");
    busy_len = 6;

    // Transmitter never goes busy
    model_en = 1'b0;
    sb.push_back('{2'd3, 8'h13});
    rem[3] = 1;
    wait_start("wd_start");
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 1; k <= 10; k++) begin
      cyc(1);
      chk($sformatf("wd_err_%0d", k), bus.err, 32'(k == 9));
    end
    chk("wd_gap_active", bus.active, 1);
    wait_idle("wd_idle");
`else
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      chk($sformatf("nowd_err_%0d", k), bus.err, 0);
    end
    chk("nowd_active", bus.active, 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("nowd_active_after_rst", bus.active, 0);
`endif
    model_en = 1'b1;

    // GAP_CYCLES=0 instance: latency and back-to-back spacing
    bus0.req = 4'b0011;
    cyc(1);
    chk("g0_latency", bus0.tx_start, 1);
    chk("g0_grant_a", bus0.grant_id, 0);
    chk("g0_data_a", bus0.tx_data, 8'h31);
    chk("g0_ack_a", bus0.ack, 4'b0001);
    bus0.req = 4'b0010;
    cyc(3);
    bus0.tx_busy = 1'b1;
    cyc(5);
    bus0.tx_busy = 1'b0;
    t = 0;
    do begin cyc(1); t++; end while (t < 20 && bus0.tx_start !== 1'b1);
    chk("g0_spacing", t, 2);
    chk("g0_grant_b", bus0.grant_id, 1);
    chk("g0_data_b", bus0.tx_data, 8'h32);
    chk("g0_ack_b", bus0.ack, 4'b0010);
    bus0.req = '0;
    cyc(3);
    bus0.tx_busy = 1'b1;
    cyc(3);
    bus0.tx_busy = 1'b0;
    cyc(3);
    chk("g0_idle", bus0.active, 0);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
